hardcloud_top_example_reducer: RTL and testbench

Per-packet lane-sum reducer sitting directly downstream of the pipelined constant adder in the example kernel. It consumes the adder's AXI4-Stream output. For each packet (terminated by tlast) it sums every kept C_ADDER_BIT_WIDTH-bit lane of every beat into a wide accumulator. It then emits one single-beat result packet carrying the sum, the beat count and the packet index. Used by the host to check adder results without reading back the full data stream.

---
 rtl/hardcloud_top_example_reducer.sv | 196 +++++++++++++++++++
 tb/tb_hardcloud_top_example_reducer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hardcloud_top_example_reducer.sv
// hardcloud_top_example_reducer
// Per-packet lane-sum reducer placed after the example constant adder.
// Every beat's kept lanes are summed into a registered stage-1 value, folded
// into a wide accumulator, and each packet (closed by tlast) produces a single
// result beat: {packet index, beat count, sum} packed into the low bits.

module hardcloud_top_example_reducer #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_ADDER_BIT_WIDTH  = 32,
    parameter int C_ACC_WIDTH        = 64
) (
    input  logic                            aclk,
    input  logic                            aresetn,

    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                            s_axis_tlast,

    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                            m_axis_tlast,

    output logic [31:0]                     pkt_count
);

    localparam int LP_NUM_LANES  = C_AXIS_TDATA_WIDTH / C_ADDER_BIT_WIDTH;
    localparam int LP_LANE_BYTES = C_ADDER_BIT_WIDTH / 8;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic                          ready_q;
    logic                          accept;
    logic                          handshake;

    logic [C_ACC_WIDTH-1:0]        lane_ext;
    logic [C_ACC_WIDTH-1:0]        lane_sum;

    logic                          s1_valid;
    logic [C_ACC_WIDTH-1:0]        s1_sum;

    logic [C_ACC_WIDTH-1:0]        acc;
    logic [C_ACC_WIDTH-1:0]        flush_sum;

    logic [31:0]                   beat_count;
    logic [31:0]                   pkt_count_q;

    logic [C_AXIS_TDATA_WIDTH-1:0] result_word;
    logic [C_AXIS_TDATA_WIDTH-1:0] result_q;

    // Only the first keep bit of each lane matters; the rest are intentionally ignored.
    logic                          unused_keep;
    assign unused_keep = ^s_axis_tkeep;

    // A beat is taken only while the registered ready is up, which is only in ACCUM.
    assign accept    = s_axis_tvalid & ready_q;
    assign handshake = (state == EMIT) & m_axis_tready;

    // Sum of the kept lanes of the current beat, each zero-extended to accumulator width.
    always_comb begin
        lane_ext = '0;
        lane_sum = '0;
        for (int i = 0; i < LP_NUM_LANES; i++) begin
            lane_ext = '0;
            if (s_axis_tkeep[i*LP_LANE_BYTES]) begin
                lane_ext[C_ADDER_BIT_WIDTH-1:0] = s_axis_tdata[i*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH];
            end
            lane_sum = lane_sum + lane_ext;
        end
    end

    // Next-state decode: tlast closes a packet, FLUSH lasts one cycle, EMIT waits for the consumer.
    always_comb begin
        next_state = state;
        case (state)
            ACCUM: begin
                if (accept && s_axis_tlast) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                next_state = EMIT;
            end
            EMIT: begin
                if (m_axis_tready) begin
                    next_state = ACCUM;
                end
            end
            default: begin
                next_state = ACCUM;
            end
        endcase
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // Input ready is a registered decode of the upcoming state so it is low throughout reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (next_state == ACCUM);
        end
    end

    // Stage 1: register the per-beat lane sum together with its valid flag.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_sum <= lane_sum;
            end
        end
    end

    // The last beat's stage-1 value is still in flight during FLUSH, so fold it in here.
    always_comb begin
        flush_sum = acc + (s1_valid ? s1_sum : '0);
    end

    // Accumulate stage-1 sums while collecting a packet; clear once the result is captured.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            acc <= '0;
        end else if (state == FLUSH) begin
            acc <= '0;
        end else if ((state == ACCUM) && s1_valid) begin
            acc <= acc + s1_sum;
        end
    end

    // Count accepted beats (empty-keep beats included), saturating, cleared when the result is taken.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            beat_count <= '0;
        end else if (handshake) begin
            beat_count <= '0;
        end else if (accept && (beat_count != 32'hFFFF_FFFF)) begin
            beat_count <= beat_count + 32'd1;
        end
    end

    // Pack the result word: sum in the low field, then beat count, then packet index.
    always_comb begin
        result_word                                = '0;
        result_word[C_ACC_WIDTH-1:0]               = flush_sum;
        result_word[C_ACC_WIDTH +: 32]             = beat_count;
        result_word[C_ACC_WIDTH+32 +: 32]          = pkt_count_q;
    end

    // Output register loaded at the end of FLUSH and held untouched through EMIT.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            result_q <= '0;
        end else if (state == FLUSH) begin
            result_q <= result_word;
        end
    end

    // Number of results the consumer has accepted since reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pkt_count_q <= '0;
        end else if (handshake) begin
            pkt_count_q <= pkt_count_q + 32'd1;
        end
    end

    assign s_axis_tready = ready_q;
    assign m_axis_tvalid = (state == EMIT);
    assign m_axis_tdata  = result_q;
    assign m_axis_tkeep  = '1;
    assign m_axis_tlast  = 1'b1;
    assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_hardcloud_top_example_reducer.sv
// Directed bench for hardcloud_top_example_reducer.
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
// A second instance with a 36-bit accumulator shares the same stimulus to exercise wrap-around.

module tb_hardcloud_top_example_reducer;

    localparam int DW = 512;
    localparam int KW = DW / 8;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          s_tvalid;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast;
    logic          m_tready;

    logic          a_s_tready, a_m_tvalid, a_m_tlast;
    logic [DW-1:0] a_m_tdata;
    logic [KW-1:0] a_m_tkeep;
    logic [31:0]   a_pkt_count;

    logic          b_s_tready, b_m_tvalid, b_m_tlast;
    logic [DW-1:0] b_m_tdata;
    logic [KW-1:0] b_m_tkeep;
    logic [31:0]   b_pkt_count;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [DW-1:0] wrap_expected;

    // Free-running clock.
    always #5 clk = ~clk;

    hardcloud_top_example_reducer #(
        .C_AXIS_TDATA_WIDTH(DW),
        .C_ADDER_BIT_WIDTH (32),
        .C_ACC_WIDTH       (64)
    ) dut_a (
        .aclk         (clk),
        .aresetn      (aresetn),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(a_s_tready),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tlast (s_tlast),
        .m_axis_tvalid(a_m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tdata (a_m_tdata),
        .m_axis_tkeep (a_m_tkeep),
        .m_axis_tlast (a_m_tlast),
        .pkt_count    (a_pkt_count)
    );

    hardcloud_top_example_reducer #(
        .C_AXIS_TDATA_WIDTH(DW),
        .C_ADDER_BIT_WIDTH (32),
        .C_ACC_WIDTH       (36)
    ) dut_b (
        .aclk         (clk),
        .aresetn      (aresetn),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(b_s_tready),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tlast (s_tlast),
        .m_axis_tvalid(b_m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tdata (b_m_tdata),
        .m_axis_tkeep (b_m_tkeep),
        .m_axis_tlast (b_m_tlast),
        .pkt_count    (b_pkt_count)
    );

    function automatic logic [DW-1:0] fillLanes(input logic [31:0] v);
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = v;
        return d;
    endfunction

    function automatic logic [DW-1:0] laneIndexData();
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = 32'(i + 1);
        return d;
    endfunction

    // Result layout for the 64-bit accumulator instance.
    function automatic logic [DW-1:0] resultWord(input logic [63:0] sum, input logic [31:0] cnt,
                                                 input logic [31:0] idx);
        logic [DW-1:0] r;
        r         = '0;
        r[63:0]   = sum;
        r[95:64]  = cnt;
        r[127:96] = idx;
        return r;
    endfunction

    task automatic applyStimulus(input logic valid, input logic [DW-1:0] data,
                                 input logic [KW-1:0] keep, input logic last);
        s_tvalid = valid;
        s_tdata  = data;
        s_tkeep  = keep;
        s_tlast  = last;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        total++;
        assert (observed === expected) begin
            passed++;
        end else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Guard against a stuck run.
    initial begin
        #200000;
        $fatal(1, "[TB] FAIL watchdog: sequence did not complete");
    end

    // Directed sequence.
    initial begin
        aresetn  = 1'b0;
        m_tready = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_s_tready", a_s_tready, 1'b0);
        checkOutput("rst_m_tvalid", a_m_tvalid, 1'b0);
        checkOutput("rst_m_tdata", a_m_tdata, '0);
        checkOutput("rst_pkt_count", a_pkt_count, 32'd0);

        aresetn = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_s_tready", a_s_tready, 1'b1);
        checkOutput("m_tkeep", a_m_tkeep, {KW{1'b1}});
        checkOutput("m_tlast", a_m_tlast, 1'b1);

        $display("[TB] single-beat packet with backpressure");
        applyStimulus(1'b1, fillLanes(32'd1), '1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 1'b0);
        checkOutput("t1_flush_tvalid", a_m_tvalid, 1'b0);
        checkOutput("t1_flush_tready", a_s_tready, 1'b0);
        @(negedge clk);
        checkOutput("t1_emit_tvalid", a_m_tvalid, 1'b1);
        checkOutput("t1_emit_tdata", a_m_tdata, resultWord(64'd16, 32'd1, 32'd0));
        applyStimulus(1'b1, fillLanes(32'd100), '1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("t1_bp_tvalid", a_m_tvalid, 1'b1);
            checkOutput("t1_bp_tdata", a_m_tdata, resultWord(64'd16, 32'd1, 32'd0));
            checkOutput("t1_bp_s_tready", a_s_tready, 1'b0);
            checkOutput("t1_bp_pkt_count", a_pkt_count, 32'd0);
        end
        applyStimulus(1'b0, '0, '0, 1'b0);
        m_tready = 1'b1;
        @(negedge clk);
        checkOutput("t1_done_tvalid", a_m_tvalid, 1'b0);
        checkOutput("t1_done_pkt_count", a_pkt_count, 32'd1);
        checkOutput("t1_done_s_tready", a_s_tready, 1'b1);

        $display("[TB] three-beat packet with partial keep");
        applyStimulus(1'b1, laneIndexData(), '1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, laneIndexData(), 64'h000F, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, laneIndexData(), '0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 1'b0);
        checkOutput("t2_flush_tvalid", a_m_tvalid, 1'b0);
        @(negedge clk);
        checkOutput("t2_emit_tvalid", a_m_tvalid, 1'b1);
        checkOutput("t2_emit_tdata", a_m_tdata, resultWord(64'd137, 32'd3, 32'd1));
        @(negedge clk);
        checkOutput("t2_done_tvalid", a_m_tvalid, 1'b0);
        checkOutput("t2_done_pkt_count", a_pkt_count, 32'd2);

        $display("[TB] back-to-back single-beat packets");
        applyStimulus(1'b1, fillLanes(32'd3), '1, 1'b1);
        @(negedge clk);
        checkOutput("t4_c1_s_tready", a_s_tready, 1'b0);
        applyStimulus(1'b1, fillLanes(32'd5), '1, 1'b1);
        @(negedge clk);
        checkOutput("t4_c2_s_tready", a_s_tready, 1'b0);
        checkOutput("t4_a_tvalid", a_m_tvalid, 1'b1);
        checkOutput("t4_a_tdata", a_m_tdata, resultWord(64'd48, 32'd1, 32'd2));
        @(negedge clk);
        checkOutput("t4_c3_s_tready", a_s_tready, 1'b1);
        checkOutput("t4_c3_tvalid", a_m_tvalid, 1'b0);
        checkOutput("t4_c3_pkt_count", a_pkt_count, 32'd3);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 1'b0);
        checkOutput("t4_b_flush_s_tready", a_s_tready, 1'b0);
        @(negedge clk);
        checkOutput("t4_b_tvalid", a_m_tvalid, 1'b1);
        checkOutput("t4_b_tdata", a_m_tdata, resultWord(64'd80, 32'd1, 32'd3));
        @(negedge clk);
        checkOutput("t4_done_pkt_count", a_pkt_count, 32'd4);

        $display("[TB] accumulator wrap");
        wrap_expected          = '0;
        wrap_expected[35:0]    = 36'hF_FFFF_FFE0;
        wrap_expected[67:36]   = 32'd2;
        wrap_expected[99:68]   = 32'd4;
        applyStimulus(1'b1, fillLanes(32'hFFFF_FFFF), '1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, fillLanes(32'hFFFF_FFFF), '1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        checkOutput("t5_b_tvalid", b_m_tvalid, 1'b1);
        checkOutput("t5_b_tdata_wrap", b_m_tdata, wrap_expected);
        checkOutput("t5_a_tdata_wide", a_m_tdata, resultWord(64'h1F_FFFF_FFE0, 32'd2, 32'd4));
        @(negedge clk);
        checkOutput("t5_b_pkt_count", b_pkt_count, 32'd5);

        $display("[TB] reset mid-packet");
        applyStimulus(1'b1, fillLanes(32'd7), '1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        aresetn = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        checkOutput("t6_rst_s_tready", a_s_tready, 1'b0);
        checkOutput("t6_rst_pkt_count", a_pkt_count, 32'd0);
        checkOutput("t6_rst_tvalid", a_m_tvalid, 1'b0);
        checkOutput("t6_rst_tdata", a_m_tdata, '0);
        aresetn = 1'b1;
        @(negedge clk);
        checkOutput("t6_rel_s_tready", a_s_tready, 1'b1);
        applyStimulus(1'b1, fillLanes(32'd2), '1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        checkOutput("t6_tvalid", a_m_tvalid, 1'b1);
        checkOutput("t6_tdata", a_m_tdata, resultWord(64'd32, 32'd1, 32'd0));
        @(negedge clk);
        checkOutput("t6_pkt_count", a_pkt_count, 32'd1);
        checkOutput("t6_b_pkt_count", b_pkt_count, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
